// File: rtl/sram_stream_pkg.sv
// rtl/sram_stream_pkg.sv - shared widths, constants and FSM state type for the SRAM row streamer
package sram_stream_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 9;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/sram_skid_fifo2.sv
// rtl/sram_skid_fifo2.sv - two-entry fall-through FIFO carrying {last, data} between the SRAM and the read stream
module sram_skid_fifo2
  import sram_stream_pkg::*;
#(
  parameter int W = DATA_W + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_empty;
  logic w_pass;
  logic w_store;
  logic w_take;

  // When empty, the SRAM word is presented the same cycle it arrives, saving a cycle of read latency.
  assign w_empty = (r_count == 2'd0);
  assign w_pass  = w_empty & i_push & i_pop;
  assign w_store = i_push & ~w_pass;
  assign w_take  = i_pop & ~w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) r_wr_ptr <= ~r_wr_ptr;
      if (w_take)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_take};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_store) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = ~w_empty | i_push;
  assign o_head  = w_empty ? i_push_data : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_row_streamer.sv
// rtl/sram_row_streamer.sv - turns row commands into SRAM port-2 word accesses with a credited read stream
module sram_row_streamer
  import sram_stream_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_last,
  input  logic              i_rd_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_address2,
  output logic              o_chipselect2,
  output logic              o_write2,
  output logic [3:0]        o_byteenable2,
  output logic [DATA_W-1:0] o_writedata2,
  output logic              o_clken2,
  input  logic [DATA_W-1:0] i_readdata2
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_returned;
  logic [LEN_W-1:0]  r_accepted;
  logic              r_inflight;
  logic              r_err;

  logic              w_pop;
  logic              w_issue;
  logic              w_beat;
  logic [2:0]        w_credit;
  logic              w_push_last;
  logic              w_fifo_valid;
  logic [DATA_W:0]   w_head;
  logic [1:0]        w_count;
  logic [LEN_W-1:0]  w_issued_nxt;
  logic              w_rows_out;

  // Outstanding words (buffered + in flight) may never exceed the two FIFO slots.
  assign w_pop        = w_fifo_valid & i_rd_ready;
  assign w_credit     = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue      = (r_state == READ) && (r_issued != r_len) && (w_credit < 3'd2);
  assign w_beat       = (r_state == WRITE) && i_wr_valid;
  assign w_issued_nxt = r_issued + {{(LEN_W-1){1'b0}}, w_issue};
  assign w_push_last  = ((r_returned + {{(LEN_W-1){1'b0}}, 1'b1}) == r_len);
  assign w_rows_out   = ((r_accepted + {{(LEN_W-1){1'b0}}, w_pop}) == r_len);

  sram_skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_reset),
    .i_push      (r_inflight),
    .i_push_data ({w_push_last, i_readdata2}),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign o_rd_valid    = w_fifo_valid;
  assign o_rd_data     = w_head[DATA_W-1:0];
  assign o_rd_last     = w_head[DATA_W] & w_fifo_valid;
  assign o_byteenable2 = BE_ALL;
  assign o_clken2      = 1'b1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_cmd_valid) w_next = (i_cmd_len == '0) ? DONE : (i_cmd_write ? WRITE : READ);
      READ:    if (w_issued_nxt == r_len) w_next = DRAIN;
      DRAIN:   if (w_rows_out) w_next = DONE;
      WRITE:   if (w_beat && ((r_issued + {{(LEN_W-1){1'b0}}, 1'b1}) == r_len)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready   = 1'b0;
    o_wr_ready    = 1'b0;
    o_chipselect2 = 1'b0;
    o_write2      = 1'b0;
    o_address2    = '0;
    o_writedata2  = '0;
    o_done        = 1'b0;
    o_err         = 1'b0;
    case (r_state)
      IDLE: o_cmd_ready = 1'b1;
      READ: begin
        o_chipselect2 = w_issue;
        o_address2    = w_issue ? r_addr : '0;
      end
      WRITE: begin
        o_wr_ready = 1'b1;
        if (i_wr_valid) begin
          o_chipselect2 = 1'b1;
          o_write2      = 1'b1;
          o_address2    = r_addr;
          o_writedata2  = i_wr_data;
        end
      end
      DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (r_state == IDLE && i_cmd_valid) begin
        r_addr     <= i_cmd_addr;
        r_len      <= i_cmd_len;
        r_issued   <= '0;
        r_returned <= '0;
        r_accepted <= '0;
        r_err      <= (i_cmd_len == '0);
      end else begin
        // Address wraps 255 -> 0 by plain overflow of the 8-bit counter.
        if (w_issue || w_beat) begin
          r_addr   <= r_addr + 1'b1;
          r_issued <= r_issued + 1'b1;
        end
        if (r_inflight) r_returned <= r_returned + 1'b1;
        if (w_pop)      r_accepted <= r_accepted + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_row_streamer.sv
// tb/tb_sram_row_streamer.sv - scoreboard bench for sram_row_streamer with a behavioural 256x32 SRAM
module tb_sram_row_streamer;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic        done, err;
  logic [7:0]  address2;
  logic        chipselect2, write2;
  logic [3:0]  byteenable2;
  logic [31:0] writedata2;
  logic        clken2;
  logic [31:0] readdata2;

  sram_row_streamer dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_last(rd_last), .i_rd_ready(rd_ready),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_done(done), .o_err(err),
    .o_address2(address2), .o_chipselect2(chipselect2), .o_write2(write2),
    .o_byteenable2(byteenable2), .o_writedata2(writedata2), .o_clken2(clken2),
    .i_readdata2(readdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: registered address, unregistered q.
  logic [31:0] mem [256];
  logic [7:0]  rq_addr = 8'h0;
  always @(posedge clk) begin
    if (chipselect2) begin
      if (write2) mem[address2] <= writedata2;
      else        rq_addr <= address2;
    end
  end
  assign readdata2 = mem[rq_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_DONE = 0, S_ERR = 1, S_CRDY = 2, S_CS = 3, S_WR2 = 4, S_ADDR = 5,
                 S_RVAL = 6, S_RLAST = 7, S_WRDY = 8, S_WDATA = 9, S_BE = 10, S_CLKEN = 11,
                 S_MEM = 12, S_RDATA = 13;

  typedef struct {
    int          cyc;
    int          sig;
    logic [7:0]  a;
    logic [31:0] val;
  } exp_t;

  exp_t        expq[$];
  logic [32:0] rdq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          outst = 0;
  logic        fin_req = 1'b0;
  logic        fin_ack = 1'b0;

  function automatic logic [31:0] sig_val(input int s, input logic [7:0] a);
    case (s)
      S_DONE:  return {31'b0, done};
      S_ERR:   return {31'b0, err};
      S_CRDY:  return {31'b0, cmd_ready};
      S_CS:    return {31'b0, chipselect2};
      S_WR2:   return {31'b0, write2};
      S_ADDR:  return {24'b0, address2};
      S_RVAL:  return {31'b0, rd_valid};
      S_RLAST: return {31'b0, rd_last};
      S_WRDY:  return {31'b0, wr_ready};
      S_WDATA: return writedata2;
      S_BE:    return {28'b0, byteenable2};
      S_CLKEN: return {31'b0, clken2};
      S_MEM:   return mem[a];
      default: return rd_data;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_DONE:  return "done";
      S_ERR:   return "err";
      S_CRDY:  return "cmd_ready";
      S_CS:    return "chipselect2";
      S_WR2:   return "write2";
      S_ADDR:  return "address2";
      S_RVAL:  return "rd_valid";
      S_RLAST: return "rd_last";
      S_WRDY:  return "wr_ready";
      S_WDATA: return "writedata2";
      S_BE:    return "byteenable2";
      S_CLKEN: return "clken2";
      S_MEM:   return "sram_word";
      default: return "rd_data";
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input logic [31:0] v, input logic [7:0] a = 8'h0);
    exp_t e;
    e.cyc = c; e.sig = s; e.a = a; e.val = v;
    expq.push_back(e);
  endtask

  // Monitor: all comparisons happen here, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = expq.size() - 1; i >= 0; i--) begin
        if (expq[i].cyc == cyc) begin
          n_vec++;
          if (sig_val(expq[i].sig, expq[i].a) !== expq[i].val) begin
            n_err++;
            $display("FAIL %s cyc=%0d addr=%0h got=%0h want=%0h", sig_name(expq[i].sig), cyc,
                     expq[i].a, sig_val(expq[i].sig, expq[i].a), expq[i].val);
          end
          expq.delete(i);
        end
      end
      if (!rst && rd_valid && rd_ready) begin
        n_vec++;
        if (rdq.size() == 0) begin
          n_err++;
          $display("FAIL rd_beat_extra cyc=%0d got=%0h want=none", cyc, {rd_last, rd_data});
        end else begin
          if ({rd_last, rd_data} !== rdq[0]) begin
            n_err++;
            $display("FAIL rd_beat cyc=%0d got=%0h want=%0h", cyc, {rd_last, rd_data}, rdq[0]);
          end
          void'(rdq.pop_front());
        end
      end
      if (rst) outst = 0;
      else begin
        if (chipselect2 && !write2) outst++;
        if (rd_valid && rd_ready) outst--;
        if (chipselect2 && !write2) begin
          n_vec++;
          if (outst > 2) begin
            n_err++;
            $display("FAIL read_credit cyc=%0d got=%0d want<=2", cyc, outst);
          end
        end
      end
      if (fin_req && !fin_ack) begin
        n_vec++;
        if (rdq.size() != 0) begin
          n_err++;
          $display("FAIL rd_beats_missing got=%0d want=0", rdq.size());
        end
        n_vec++;
        if (expq.size() != 0) begin
          n_err++;
          $display("FAIL checks_unreached got=%0d want=0", expq.size());
        end
        fin_ack = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [8:0] l, output int t);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (cmd_ready) break;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) break;
    end
  endtask

  int          t;
  logic [15:0] pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h90 + i;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_len = 9'h0;
    rd_ready = 1'b1; wr_valid = 1'b0; wr_data = 32'h0;
    expect_at(2, S_CRDY, 1);  expect_at(2, S_RVAL, 0);  expect_at(2, S_RLAST, 0);
    expect_at(2, S_WRDY, 0);  expect_at(2, S_DONE, 0);  expect_at(2, S_ERR, 0);
    expect_at(2, S_CS, 0);    expect_at(2, S_WR2, 0);   expect_at(2, S_ADDR, 0);
    expect_at(2, S_WDATA, 0); expect_at(2, S_BE, 32'hF); expect_at(2, S_CLKEN, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic row read
    send_cmd(1'b0, 8'h10, 9'd4, t);
    rdq.push_back({1'b0, 32'hA0}); rdq.push_back({1'b0, 32'hA1});
    rdq.push_back({1'b0, 32'hA2}); rdq.push_back({1'b1, 32'hA3});
    expect_at(t + 1, S_CS, 1);   expect_at(t + 1, S_ADDR, 32'h10); expect_at(t + 1, S_CRDY, 0);
    expect_at(t + 2, S_RVAL, 1); expect_at(t + 4, S_RLAST, 0);     expect_at(t + 5, S_RLAST, 1);
    expect_at(t + 5, S_DONE, 0); expect_at(t + 6, S_DONE, 1);      expect_at(t + 6, S_ERR, 0);
    expect_at(t + 7, S_CRDY, 1);
    wait_done(40);

    // Back-pressured read
    pat = 16'b1010_0110_1100_1011;
    send_cmd(1'b0, 8'h30, 9'd8, t);
    for (int i = 0; i < 8; i++) rdq.push_back({(i == 7), 32'hC0 + 32'(i)});
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      rd_ready = pat[k % 16];
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk); #1 rd_ready = 1'b1;

    // Address wrap
    send_cmd(1'b0, 8'hFE, 9'd4, t);
    rdq.push_back({1'b0, 32'h18E}); rdq.push_back({1'b0, 32'h18F});
    rdq.push_back({1'b0, 32'h90});  rdq.push_back({1'b1, 32'h91});
    expect_at(t + 1, S_ADDR, 32'hFE); expect_at(t + 2, S_ADDR, 32'hFF);
    expect_at(t + 3, S_ADDR, 32'h00); expect_at(t + 4, S_ADDR, 32'h01);
    expect_at(t + 6, S_DONE, 1);
    wait_done(40);

    // Gapped write
    send_cmd(1'b1, 8'h20, 9'd3, t);
    expect_at(t + 1, S_WR2, 1); expect_at(t + 1, S_ADDR, 32'h20); expect_at(t + 1, S_WDATA, 32'h1111_0001);
    expect_at(t + 1, S_WRDY, 1);
    expect_at(t + 2, S_WR2, 0); expect_at(t + 2, S_CS, 0);
    expect_at(t + 3, S_WR2, 1); expect_at(t + 3, S_ADDR, 32'h21);
    expect_at(t + 4, S_WR2, 0);
    expect_at(t + 5, S_WR2, 1); expect_at(t + 5, S_ADDR, 32'h22); expect_at(t + 5, S_DONE, 0);
    expect_at(t + 6, S_DONE, 1); expect_at(t + 6, S_WRDY, 0);
    expect_at(t + 7, S_MEM, 32'h1111_0001, 8'h20);
    expect_at(t + 7, S_MEM, 32'h2222_0002, 8'h21);
    expect_at(t + 7, S_MEM, 32'h3333_0003, 8'h22);
    wr_valid = 1'b1; wr_data = 32'h1111_0001;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(posedge clk); #1 wr_valid = 1'b1; wr_data = 32'h2222_0002;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(posedge clk); #1 wr_valid = 1'b1; wr_data = 32'h3333_0003;
    @(posedge clk); #1 wr_valid = 1'b0;
    wait_done(20);

    // Zero-length command
    send_cmd(1'b0, 8'h50, 9'd0, t);
    expect_at(t + 1, S_DONE, 1); expect_at(t + 1, S_ERR, 1); expect_at(t + 1, S_CS, 0);
    expect_at(t + 2, S_ERR, 0);  expect_at(t + 2, S_CRDY, 1); expect_at(t + 2, S_CS, 0);
    wait_done(20);

    // Reset mid-read with both FIFO slots full
    rd_ready = 1'b0;
    send_cmd(1'b0, 8'h40, 9'd8, t);
    expect_at(t + 3, S_CS, 0); expect_at(t + 4, S_RVAL, 1); expect_at(t + 4, S_RDATA, 32'hD0);
    repeat (4) @(posedge clk);
    #1;
    expect_at(cyc, S_RVAL, 0); expect_at(cyc, S_CS, 0);    expect_at(cyc, S_CRDY, 1);
    expect_at(cyc, S_ADDR, 0); expect_at(cyc, S_RLAST, 0); expect_at(cyc, S_DONE, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rd_ready = 1'b1;
    send_cmd(1'b0, 8'h10, 9'd2, t);
    rdq.push_back({1'b0, 32'hA0}); rdq.push_back({1'b1, 32'hA1});
    expect_at(t + 2, S_RVAL, 1); expect_at(t + 2, S_RDATA, 32'hA0); expect_at(t + 4, S_DONE, 1);
    wait_done(40);

    repeat (3) @(posedge clk);
    fin_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (fin_ack) break;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_row_streamer.md
# sram_row_streamer

Sequencer that owns the FPGA-side port (s2) of the 256×32 dual-port on-chip SRAM shared with the HPS. It converts a row command (base address, word count, direction) into word-by-word SRAM port-2 accesses. Read rows are streamed to the solver datapath with valid/ready handshaking. Result words returned by the solver are written back sequentially.

## Interface
- ADDR_W, 8, SRAM word-address width
- DATA_W, 32, SRAM word width
- LEN_W, 9, command length width (1..256 words)

- clk  in  1  single clock; also drives SRAM clk2
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  0 = read row to stream, 1 = write stream to SRAM
- cmd_addr  in  ADDR_W  first word address
- cmd_len  in  LEN_W  word count
- rd_data  out  DATA_W  read stream data
- rd_valid  out  1  read stream valid
- rd_last  out  1  marks final word of the row
- rd_ready  in  1  downstream accept
- wr_data  in  DATA_W  write stream data
- wr_valid  in  1  write stream valid
- wr_ready  out  1  write beat accept
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for a rejected command
- address2  out  ADDR_W  SRAM port-2 address
- chipselect2  out  1  SRAM port-2 select
- write2  out  1  SRAM port-2 write
- byteenable2  out  4  always 4'hF
- writedata2  out  DATA_W  SRAM port-2 write data
- clken2  out  1  tied 1
- readdata2  in  DATA_W  SRAM port-2 read data

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - cmd_ready=1.
  - cmd_valid with cmd_len=0: go to DONE with err set. No SRAM access.
  - Otherwise latch addr and len, zero the issue and return counters, then go to READ (cmd_write=0) or WRITE (cmd_write=1).
- READ:
  - Issue one read per cycle while credit is available: chipselect2=1, write2=0, address2=cur_addr.
  - After each issue: cur_addr increments modulo 256 (wraps 255→0), issued increments.
  - When issued==len, go to DRAIN.
- DRAIN: wait until every issued word has been accepted downstream, then go to DONE.
- Credit rule: issue allowed when fifo_count + inflight − pop_this_cycle < 2.
  - 2-entry output FIFO.
  - inflight is 0 or 1.
- rd_last=1 on the FIFO head when it is the len-th returned word.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready beat drives chipselect2=1, write2=1, address2=cur_addr, writedata2=wr_data in the same cycle.
  - cur_addr increments with wrap.
  - After the len-th beat, go to DONE.
- DONE: done=1 (err=1 if the command was rejected) for one cycle, then IDLE.
- Reset (asserted at any time, including mid-row): state=IDLE, counters cleared, FIFO flushed. Read data in flight is discarded.
- HPS-side coherence is software's job; this block makes no mixed-port read-during-write guarantee.

## Timing
- Reset values: cmd_ready=1, rd_valid=0, rd_last=0, wr_ready=0, done=0, err=0, chipselect2=0, write2=0, address2=0, writedata2=0, byteenable2=4'hF, clken2=1.
- Command accept cycle T: first SRAM access at T+1.
- SRAM read latency is 1 cycle (address registered, q unregistered): readdata2 is captured into the FIFO at issue+1.
- First rd_valid at T+2.
- With rd_ready held high, a len-word row streams at 1 word/cycle. rd_last is at T+len+1. done is at T+len+2.
- With rd_ready held low, at most 2 words are buffered and issue stalls. rd_data and rd_valid stay stable until accepted.
- Write: each beat is written in its own handshake cycle, zero added latency. done is the cycle after the len-th beat.
- Rejected command: done=err=1 at T+1.
- A new command may be accepted in the cycle after done.

## Structure
- Package sram_stream_pkg holds:
  - ADDR_W, DATA_W, LEN_W
  - state enum (IDLE, READ, DRAIN, WRITE, DONE)
  - BE_ALL=4'hF
- Sub-module sram_skid_fifo2: 2-entry FIFO carrying {last, data}, with count output, push/pop, and async reset flush.
- Top level holds the FSM, address/issue/return counters, inflight flag and credit logic.

## Test plan
- Read addr=0x10, len=4, memory holds 0xA0..0xA3, rd_ready=1 → rd_data A0,A1,A2,A3 on consecutive cycles starting T+2; rd_last only on A3; done at T+6.
- Read len=8, rd_ready toggled 1/0 pseudo-randomly → in-order data with none lost or duplicated; never more than 2 words issued ahead of acceptance.
- Read addr=0xFE, len=4 → address2 sequence FE, FF, 00, 01.
- Write addr=0x20, len=3, wr_valid gapped → SRAM 0x20..0x22 hold the three beats; write2 high only on handshake cycles; done the cycle after the third beat.
- cmd_len=0 → done=err=1 at T+1; chipselect2 never asserted.
- reset asserted mid-read with 2 words buffered → all outputs at reset values at once; the next command starts cleanly with no stale data.
